// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the UART transmit path.
//   BYTE_W      : width of one serial data byte
//   txq_state_t : launch controller states of uart_tx_queue
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        Q_IDLE   = 2'd0,
        Q_LAUNCH = 2'd1,
        Q_WAIT   = 2'd2
    } txq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered head (no fall-through); reusable by the
//   UART RX path.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous empty (pointers and count), wins over push/pop
//   push       : store wr_data (ignored when full)
//   pop        : drop head entry (ignored when empty)
//   wr_data    : entry to store
//   rd_data    : current head entry (undefined when empty)
//   full/empty : count == DEPTH / count == 0
//   count      : entries currently stored
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full queue drops the write even when a pop happens in the same cycle.
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// -----------------------------------------------------------------------------
// uart_tx_queue
//   Byte queue and launch controller in front of the UART transmitter. Bytes
//   pushed on wr_en are buffered and handed to the transmitter one at a time:
//   one trmt strobe per byte, then wait for tx_done before the next launch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (dropped and flagged as overflow when full)
//   wr_data    : byte to queue
//   flush      : clear queue contents and overflow (in-flight byte completes)
//   clr_ovf    : clear overflow only (a simultaneous overflowing write wins)
//   full/empty : queue full / empty
//   count      : queued bytes, excluding the one in flight
//   overflow   : sticky, a write was attempted while full
//   busy       : a byte is in flight or the queue is non-empty
//   trmt       : one-cycle launch strobe to the transmitter
//   tx_data    : byte for the transmitter, held until the next launch
//   tx_done    : transmitter done level, cleared by it on accepted trmt
// -----------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              flush,
    input  logic              clr_ovf,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy,
    output logic              trmt,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done
);

    txq_state_t        state_q, state_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              overflow_q, overflow_d;
    logic [BYTE_W-1:0] head_data;
    logic              fifo_push;
    logic              fifo_pop;

    // Flush wins over a same-cycle write, and also holds off a launch so
    // the cleared queue cannot leak a stale head byte.
    assign fifo_push = wr_en & ~flush;
    assign fifo_pop  = (state_q == Q_IDLE) & ~empty & ~flush;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (wr_data),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            Q_IDLE: begin
                if (fifo_pop) begin
                    state_d   = Q_LAUNCH;
                    tx_data_d = head_data;
                end
            end
            Q_LAUNCH: begin
                // tx_done still reflects the previous byte here; ignore it.
                state_d = Q_WAIT;
            end
            Q_WAIT: begin
                if (tx_done) state_d = Q_IDLE;
            end
            default: state_d = Q_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end else if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= Q_IDLE;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

    // trmt decoded straight from the state register keeps it glitch-free.
    assign trmt     = (state_q == Q_LAUNCH);
    assign tx_data  = tx_data_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != Q_IDLE) | ~empty;

endmodule
